// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the CPU, then copies one 256-byte page to the OAM data port
// as alternating read/write cycles on the borrowed address bus.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic [1:0]  addr_sel,
    output logic [15:0] dma_addr,
    output logic        dma_we,
    output logic [7:0]  dma_dout,
    output logic        busy
);

    localparam logic [15:0] PAGE_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [1:0]  CPU_SEL       = 2'b00;
    localparam logic [1:0]  DMA_SEL       = 2'b01;
    localparam logic [7:0]  LAST_IDX      = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  buf_q, buf_d;
    logic        odd_q;
    logic        rdy_q, rdy_d;
    logic [1:0]  addr_sel_q, addr_sel_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic        dma_we_q, dma_we_d;
    logic        busy_q, busy_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            buf_q      <= 8'h00;
            odd_q      <= 1'b0;
            rdy_q      <= 1'b1;
            addr_sel_q <= CPU_SEL;
            dma_addr_q <= 16'h0000;
            dma_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            odd_q      <= ~odd_q;
            rdy_q      <= rdy_d;
            addr_sel_q <= addr_sel_d;
            dma_addr_q <= dma_addr_d;
            dma_we_q   <= dma_we_d;
            busy_q     <= busy_d;
        end
    end

    // Next state; triggers are honoured only while already idle
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_we && (cpu_addr == PAGE_REG_ADDR)) begin
                    state_d = S_HALT;
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                end
            end
            S_HALT:  state_d = odd_q ? S_READ : S_ALIGN;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                buf_d   = bus_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs precomputed from the upcoming state so they are flop-driven
    always_comb begin
        rdy_d      = 1'b0;
        busy_d     = 1'b1;
        addr_sel_d = CPU_SEL;
        dma_we_d   = 1'b0;
        dma_addr_d = dma_addr_q;
        unique case (state_d)
            S_IDLE: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
            S_READ: begin
                addr_sel_d = DMA_SEL;
                dma_addr_d = {page_d, idx_d};
            end
            S_WRITE: begin
                addr_sel_d = DMA_SEL;
                dma_addr_d = OAM_DATA_ADDR;
                dma_we_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rdy      = rdy_q;
    assign addr_sel = addr_sel_q;
    assign dma_addr = dma_addr_q;
    assign dma_we   = dma_we_q;
    assign dma_dout = buf_q;
    assign busy     = busy_q;

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA sequencer that borrows the 6502 address bus from the CPU core. A CPU write to the DMA page register halts the CPU via `rdy`, steers the address latch to the DMA address source through `addr_sel`, and copies 256 bytes from page `P` (`$P00`–`$PFF`) to the OAM data port as alternating read/write cycles. When the copy finishes, it returns the bus to the CPU. It sits beside the CPU core and drives the select input of the CPU address latch.

## Interface
- `PAGE_REG_ADDR`, 16'h4014, CPU write address that starts a DMA.
- `OAM_DATA_ADDR`, 16'h2004, destination address of every DMA write cycle.
- `CPU_SEL`, 2'b00, `addr_sel` code selecting the CPU address source.
- `DMA_SEL`, 2'b01, `addr_sel` code selecting `dma_addr`.
- `clk` in 1: single clock. The address latch samples `addr_sel` on the falling edge; this block updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_addr` in 16: CPU address for the current cycle.
- `cpu_we` in 1: CPU write strobe for the current cycle.
- `cpu_dout` in 8: CPU write data.
- `bus_din` in 8: data-bus read value for the current cycle.
- `rdy` out 1: 1 = CPU runs; 0 = CPU halted.
- `addr_sel` out 2: select to the address latch.
- `dma_addr` out 16: DMA address source, wired to the latch input selected by `DMA_SEL`.
- `dma_we` out 1: DMA write strobe.
- `dma_dout` out 8: DMA write data.
- `busy` out 1: 1 in any state other than IDLE.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE. All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- **Parity bit:** `odd` resets to 0 and toggles on every `clk`, whether or not a DMA is running.
- **IDLE**
  - `rdy`=1, `addr_sel`=`CPU_SEL`, `dma_we`=0, `busy`=0.
  - When `cpu_we`=1 and `cpu_addr`==`PAGE_REG_ADDR` at a rising edge: latch `page`<=`cpu_dout`, clear `idx`<=0, go to HALT.
- **HALT** (exactly 1 cycle)
  - `rdy`=0, `addr_sel`=`CPU_SEL`.
  - If `odd`==1 during HALT, go to READ. Otherwise go to ALIGN.
- **ALIGN** (exactly 1 cycle): `rdy`=0, `addr_sel`=`CPU_SEL`. Next state is READ. This keeps every READ on an even cycle.
- **READ**
  - `rdy`=0, `addr_sel`=`DMA_SEL`, `dma_addr`={`page`,`idx`}, `dma_we`=0.
  - At the end of the cycle: `buf`<=`bus_din`. Next state is WRITE.
- **WRITE**
  - `rdy`=0, `addr_sel`=`DMA_SEL`, `dma_addr`=`OAM_DATA_ADDR`, `dma_we`=1, `dma_dout`=`buf`.
  - At the end of the cycle: if `idx`==8'hFF, go to IDLE; otherwise `idx`<=`idx`+1 and go to READ.
- **Counter width:** `idx` is 8 bits. Termination is decided by comparing against 8'hFF, not by wrap-around. The page never changes during a transfer; no carry goes into `page`.
- **Writes to `PAGE_REG_ADDR` while `busy`=1:** ignored. `page` and `idx` are unchanged.
- **Writes to `PAGE_REG_ADDR` in the same cycle that WRITE(`idx`=FF) exits to IDLE:** ignored. A new DMA starts only from a write sampled while already in IDLE.
- **Outputs outside READ/WRITE:** `dma_addr` holds its last value and `dma_dout` holds `buf`. Both are don't-care when `addr_sel`=`CPU_SEL`.

## Timing
- **Reset value of every output:** `rdy`=1, `addr_sel`=2'b00, `dma_addr`=16'h0000, `dma_we`=0, `dma_dout`=8'h00, `busy`=0.
- **Reset of internal state:** `page`=0, `idx`=0, `buf`=0, `odd`=0.
- **`rst` mid-transfer:** on the next rising edge all registers take reset values. The transfer is abandoned; no partial write completes after that edge.
- **Start latency:** the trigger write is sampled at edge T. `rdy` falls and HALT begins in cycle T+1.
- **First READ:** cycle T+2 when HALT falls on an odd cycle, T+3 otherwise.
- **Total halt length:** 513 cycles (1 HALT + 512 R/W) or 514 cycles (with ALIGN). `rdy` rises in the cycle after the last WRITE.
- **`addr_sel` timing:** `addr_sel` changes only on rising edges and is stable by the following falling edge. The address latch therefore selects the DMA source for exactly the READ/WRITE cycles.
- **`buf` capture:** `buf` captures `bus_din` at the rising edge that ends READ.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs equal their reset values; `odd` toggles starting from 0.
- **Odd-cycle start:** write 8'h02 to $4014 so HALT lands on an odd cycle → HALT, then READ of $0200. Alternating $0200…$02FF reads and $2004 writes follow, each with `dma_dout` equal to the previous `bus_din`. `rdy`=0 for exactly 513 cycles.
- **Even-cycle start:** same stimulus shifted by one cycle → ALIGN cycle present, `rdy`=0 for exactly 514 cycles, first read of $0200 on an even cycle.
- **Data path:** `bus_din` model returns the low address byte XOR 8'hA5 → the 256 `dma_we` pulses carry 8'hA5, 8'hA4, …, 8'h5A in order. The final write is followed by `rdy`=1 and `addr_sel`=00.
- **Ignored trigger:** CPU model drives a $4014 write with 8'h07 mid-transfer → `page` stays 8'h02 and the transfer still ends after `idx`=8'hFF.
- **Reset mid-transfer:** `rst`=1 during the WRITE with `idx`=8'h40 → next cycle `rdy`=1, `addr_sel`=00, `dma_we`=0, `busy`=0. A fresh $4014 write then restarts from `idx`=0.
